atm_bank_core: RTL
==================

ATM_BANK_CORE -- requirements
Module: atm_bank_core

Interface
REQ-001 SHALL have parameter NUM_ACC, default 16, number of account slots (index 0 reserved invalid).
REQ-002 SHALL have parameter BAL_W, default 16, balance/amount width.
REQ-003 SHALL have parameter PIN_W, default 16, PIN width.
REQ-004 SHALL have parameter INIT_BAL, default 1000, reset balance of every account.
REQ-005 SHALL have parameter MAX_TRIES, default 3, consecutive wrong PINs before lockout.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 start  input  1  one-cycle request strobe.
REQ-009 operation  input  3  1=deposit, 2=withdraw, 3=balance, 4=change PIN; others invalid.
REQ-010 acc_num  input  ACC_W=$clog2(NUM_ACC)  account index.
REQ-011 pin, new_pin  input  PIN_W  entered PIN / replacement PIN.
REQ-012 amount  input  BAL_W  transaction amount.
REQ-013 balance  output  BAL_W  post-transaction balance of the addressed account.
REQ-014 success, done, busy, locked  output  1  result flag / one-cycle completion strobe / request in progress / addressed account locked.
REQ-015 state  output  3  current FSM state code.

Function
REQ-016 FSM states SHALL be IDLE=0, AUTH=1, DEPOSIT=2, BALANCE=3, WITHDRAW=4, CHPIN=5, DONE=6.
REQ-017 In IDLE, start=1 SHALL latch operation, acc_num, pin, new_pin, amount and move to AUTH; start outside IDLE SHALL be ignored.
REQ-018 AUTH SHALL pass only if 1<=acc_num<NUM_ACC, operation in 1..4, account not locked and pin matches; pass -> operation state, fail -> DONE with success=0.
REQ-019 DEPOSIT: balance+amount overflowing BAL_W SHALL fail with balance unchanged; else add.
REQ-020 WITHDRAW: amount > balance SHALL fail with balance unchanged; amount == balance SHALL succeed leaving 0.
REQ-021 BALANCE SHALL succeed without modifying the table.
REQ-022 CHPIN: new_pin==0 or new_pin==current pin SHALL fail; else store new_pin.
REQ-023 Operation states SHALL last one cycle then go to DONE; DONE SHALL assert done for one cycle, then IDLE.
REQ-024 Latency: start sampled at edge k -> done=1 after edge k+3; auth failure -> done=1 after edge k+2.
REQ-025 success and balance SHALL be registered, valid while done=1 and held until next start; balance SHALL read 0 on failure.
REQ-026 busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 rst=0 at an edge SHALL force IDLE, success=0, done=0, busy=0, locked=0, balance=0, every account balance=INIT_BAL, pin[i]=1000+i, try counters 0, aborting any request with no table update.

Configuration
REQ-028 With ATM_LOCKOUT_EN defined, each account SHALL keep a wrong-PIN counter: wrong PIN increments it, correct PIN clears it, reaching MAX_TRIES sets a sticky lock cleared only by reset; locked asserts with done for a locked account.
REQ-029 Without ATM_LOCKOUT_EN, no counters SHALL exist, locked SHALL tie to 0, wrong PINs SHALL only fail.

Structure
REQ-030 Package atm_pkg SHALL hold the state enum, operation codes and init_pin function.
REQ-031 Sub-module atm_acct_table SHALL hold balance/PIN/counter arrays with one read port and one write port.

Verification
REQ-032 rst=0 two cycles, then start op=3 acc=2 pin=1002 -> done after 3 edges, success=1, balance=1000, state seen 1,3,6,0.
REQ-033 Op=2 acc=5 pin=1005 amount=1001 -> success=0, balance=0; then amount=1000 -> success=1, balance=0.
REQ-034 Op=1 acc=3 amount=65000 with BAL_W=16 -> success=0 (overflow); amount=500 -> balance=1500.
REQ-035 Op=4 acc=7 pin=1007 new_pin=4321 -> success=1; op=3 pin=1007 -> fail; pin=4321 -> balance=1000.
REQ-036 ATM_LOCKOUT_EN: three op=3 acc=4 pin=9999 -> third sets locked=1; pin=1004 -> success=0, locked=1; reset clears.
REQ-037 Reset asserted in WITHDRAW -> state=0, no done, account balance unchanged at 1000.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types for the ATM bank core: FSM states, operation codes, reset PINs.
package atm_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_AUTH     = 3'd1,
    S_DEPOSIT  = 3'd2,
    S_BALANCE  = 3'd3,
    S_WITHDRAW = 3'd4,
    S_CHPIN    = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  localparam logic [2:0] OP_DEP   = 3'd1;
  localparam logic [2:0] OP_WDR   = 3'd2;
  localparam logic [2:0] OP_BAL   = 3'd3;
  localparam logic [2:0] OP_CHPIN = 3'd4;

  function automatic logic [31:0] init_pin(input int unsigned idx);
    return 32'd1000 + 32'(idx);
  endfunction

endpackage

// File: rtl/atm_acct_table.sv
// Per-account balance/PIN storage, one async read port and one write port.
// Wrong-PIN counters and lock bits exist only when ATM_LOCKOUT_EN is defined.
module atm_acct_table
  import atm_pkg::*;
#(
  parameter int NUM_ACC  = 16,
  parameter int BAL_W    = 16,
  parameter int PIN_W    = 16,
  parameter int INIT_BAL = 1000,
  parameter int ACC_W    = 4
`ifdef ATM_LOCKOUT_EN
  ,
  parameter int TRY_W    = 2
`endif
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] rd_idx,
  output logic [BAL_W-1:0] rd_bal,
  output logic [PIN_W-1:0] rd_pin,
`ifdef ATM_LOCKOUT_EN
  output logic [TRY_W-1:0] rd_tries,
  output logic             rd_lock,
  input  logic [TRY_W-1:0] wr_tries,
  input  logic             wr_lock,
`endif
  input  logic             we,
  input  logic [ACC_W-1:0] wr_idx,
  input  logic [BAL_W-1:0] wr_bal,
  input  logic [PIN_W-1:0] wr_pin
);

  logic [BAL_W-1:0] bal_mem [NUM_ACC];
  logic [PIN_W-1:0] pin_mem [NUM_ACC];
  logic             rd_ok;
  logic             wr_ok;

  assign rd_ok = 32'(rd_idx) < NUM_ACC;
  assign wr_ok = 32'(wr_idx) < NUM_ACC;

  assign rd_bal = rd_ok ? bal_mem[rd_idx] : '0;
  assign rd_pin = rd_ok ? pin_mem[rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        bal_mem[i] <= BAL_W'(INIT_BAL);
        pin_mem[i] <= PIN_W'(init_pin(i));
      end
    end else if (we && wr_ok) begin
      bal_mem[wr_idx] <= wr_bal;
      pin_mem[wr_idx] <= wr_pin;
    end
  end

`ifdef ATM_LOCKOUT_EN
  logic [TRY_W-1:0] try_mem  [NUM_ACC];
  logic             lock_mem [NUM_ACC];

  assign rd_tries = rd_ok ? try_mem[rd_idx] : '0;
  assign rd_lock  = rd_ok ? lock_mem[rd_idx] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        try_mem[i]  <= '0;
        lock_mem[i] <= 1'b0;
      end
    end else if (we && wr_ok) begin
      try_mem[wr_idx]  <= wr_tries;
      lock_mem[wr_idx] <= wr_lock;
    end
  end
`endif

endmodule

// File: rtl/atm_bank_core.sv
// ATM transaction engine: IDLE -> AUTH -> operation -> DONE -> IDLE.
// Optional wrong-PIN lockout is enabled with ATM_LOCKOUT_EN.
module atm_bank_core
  import atm_pkg::*;
#(
  parameter  int NUM_ACC   = 16,
  parameter  int BAL_W     = 16,
  parameter  int PIN_W     = 16,
  parameter  int INIT_BAL  = 1000,
  parameter  int MAX_TRIES = 3,
  localparam int ACC_W     = $clog2(NUM_ACC)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] new_pin,
  input  logic [BAL_W-1:0] amount,
  output logic [BAL_W-1:0] balance,
  output logic             success,
  output logic             done,
  output logic             busy,
  output logic             locked,
  output logic [2:0]       state
);

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q, npin_q;
  logic [BAL_W-1:0] amt_q;

  logic [BAL_W-1:0] rd_bal, wr_bal;
  logic [PIN_W-1:0] rd_pin, wr_pin;
  logic             we;

  logic             acc_ok, op_ok, pin_ok, acct_lock, auth_ok;
  logic [BAL_W:0]   sum;
  logic             res_ok;
  logic [BAL_W-1:0] res_bal;
  logic             lock_now;

`ifdef ATM_LOCKOUT_EN
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  logic [TRY_W-1:0] rd_tries, wr_tries;
  logic             rd_lock, wr_lock;
  assign acct_lock = rd_lock;
`else
  assign acct_lock = 1'b0;
`endif

  atm_acct_table #(
    .NUM_ACC  (NUM_ACC),
    .BAL_W    (BAL_W),
    .PIN_W    (PIN_W),
    .INIT_BAL (INIT_BAL),
    .ACC_W    (ACC_W)
`ifdef ATM_LOCKOUT_EN
    ,
    .TRY_W    (TRY_W)
`endif
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (acc_q),
    .rd_bal   (rd_bal),
    .rd_pin   (rd_pin),
`ifdef ATM_LOCKOUT_EN
    .rd_tries (rd_tries),
    .rd_lock  (rd_lock),
    .wr_tries (wr_tries),
    .wr_lock  (wr_lock),
`endif
    .we       (we),
    .wr_idx   (acc_q),
    .wr_bal   (wr_bal),
    .wr_pin   (wr_pin)
  );

  assign acc_ok  = (acc_q != '0) && (32'(acc_q) < NUM_ACC);
  assign op_ok   = (op_q >= OP_DEP) && (op_q <= OP_CHPIN);
  assign pin_ok  = pin_q == rd_pin;
  assign auth_ok = acc_ok && op_ok && !acct_lock && pin_ok;
  assign sum     = {1'b0, rd_bal} + {1'b0, amt_q};

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    wr_bal  = rd_bal;
    wr_pin  = rd_pin;
    res_ok  = 1'b0;
    res_bal = '0;
`ifdef ATM_LOCKOUT_EN
    wr_tries = rd_tries;
    wr_lock  = rd_lock;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_AUTH;
      end
      S_AUTH: begin
`ifdef ATM_LOCKOUT_EN
        // Lock is sticky: a locked account's counter is frozen.
        if (acc_ok && !rd_lock) begin
          we = 1'b1;
          if (pin_ok) begin
            wr_tries = '0;
          end else begin
            wr_tries = TRY_W'(32'(rd_tries) + 1);
            wr_lock  = (32'(rd_tries) + 1) >= MAX_TRIES;
          end
        end
`endif
        if (!auth_ok) begin
          state_d = S_DONE;
        end else begin
          unique case (1'b1)
            (op_q == OP_DEP):   state_d = S_DEPOSIT;
            (op_q == OP_WDR):   state_d = S_WITHDRAW;
            (op_q == OP_BAL):   state_d = S_BALANCE;
            (op_q == OP_CHPIN): state_d = S_CHPIN;
            default:            state_d = S_DONE;
          endcase
        end
      end
      S_DEPOSIT: begin
        state_d = S_DONE;
        res_ok  = !sum[BAL_W];
        if (res_ok) begin
          we      = 1'b1;
          wr_bal  = sum[BAL_W-1:0];
          res_bal = sum[BAL_W-1:0];
        end
      end
      S_WITHDRAW: begin
        state_d = S_DONE;
        res_ok  = amt_q <= rd_bal;
        if (res_ok) begin
          we      = 1'b1;
          wr_bal  = rd_bal - amt_q;
          res_bal = rd_bal - amt_q;
        end
      end
      S_BALANCE: begin
        state_d = S_DONE;
        res_ok  = 1'b1;
        res_bal = rd_bal;
      end
      S_CHPIN: begin
        state_d = S_DONE;
        res_ok  = (npin_q != '0) && (npin_q != rd_pin);
        if (res_ok) begin
          we      = 1'b1;
          wr_pin  = npin_q;
          res_bal = rd_bal;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ATM_LOCKOUT_EN
  assign lock_now = acc_ok && wr_lock;
`else
  assign lock_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      pin_q   <= '0;
      npin_q  <= '0;
      amt_q   <= '0;
      success <= 1'b0;
      balance <= '0;
      locked  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= state_q == S_DONE;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= operation;
            acc_q   <= acc_num;
            pin_q   <= pin;
            npin_q  <= new_pin;
            amt_q   <= amount;
            success <= 1'b0;
            balance <= '0;
            locked  <= 1'b0;
          end
        end
        S_AUTH: begin
          locked <= lock_now;
          if (!auth_ok) begin
            success <= 1'b0;
            balance <= '0;
          end
        end
        S_DEPOSIT, S_WITHDRAW, S_BALANCE, S_CHPIN: begin
          success <= res_ok;
          balance <= res_bal;
        end
        default: ;
      endcase
    end
  end

  assign busy  = state_q != S_IDLE;
  assign state = state_q;

endmodule
